// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage RV32I pipeline: post-reset hold,
// load-use stalls, branch flushes, data-memory waits with timeout, perf counters.
module hazard_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             MemAccessM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {INIT, RUN, MEM_WAIT, ERROR} state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [WW-1:0] wait_cnt;
  logic          active;
  logic          memwait;
  logic          lw_stall;
  logic          branch_flush;

  assign active       = (state == RUN) || (state == MEM_WAIT);
  assign memwait      = MemAccessM & ~MemReadyM;
  assign lw_stall     = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));
  assign branch_flush = active && !memwait && PCSrcE;

  // Priority inside RUN/MEM_WAIT: memory wait, then branch, then load-use.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    unique case (state)
      INIT: begin
        StallF = 1'b1;
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
      ERROR: begin
        {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
      end
      default: begin
        if (memwait) begin
          {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
        end else if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (lw_stall) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      hold_cnt  <= '0;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (active && StallF && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_flush && !(&flush_cnt))     flush_cnt <= flush_cnt + CNT_W'(1);
      unique case (state)
        INIT: begin
          if (hold_cnt == HW'(HOLD_CYCLES - 1)) state <= RUN;
          else                                  hold_cnt <= hold_cnt + HW'(1);
        end
        RUN: begin
          wait_cnt <= '0;
          if (memwait) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (!memwait) begin
            state <= RUN;
          end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
            // The timeout cycle itself still counts as a wait.
            state   <= ERROR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: state <= ERROR;
      endcase
    end
  end

endmodule
